// File: rtl/cache_assoc.sv
// Set-associative (1- or 2-way) processor cache with a four-word block and a
// single-ported block memory interface; write-back or write-through, write-allocate.
module cache_assoc #(
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned WRITE_BACK = 1
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_WTHROUGH  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_valid [WAYS][SETS];
    logic               r_dirty [WAYS][SETS];
    logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
    logic [127:0]       r_data  [WAYS][SETS];
    logic               r_way;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim;
    logic               w_lru_bit;
    logic               w_touch;
    logic               w_wr_word;
    logic               w_fill;

    assign w_idx  = proc_addr[IDX_W+1:2];
    assign w_tag  = proc_addr[29:IDX_W+2];
    assign w_word = proc_addr[1:0];
    assign w_req  = proc_read | proc_write;

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 1'(w);
            end
        end
    end

    // Victim: first invalid way (way 0 preferred), else the LRU way
    always_comb begin
        if (!r_valid[0][w_idx]) begin
            w_victim = 1'b0;
        end else if ((WAYS == 2) && !r_valid[WAYS-1][w_idx]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = w_lru_bit;
        end
    end

    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] r_lru;
            // LRU bit names the way that was not touched most recently
            always_ff @(posedge clk) begin
                if (proc_reset) begin
                    r_lru <= '0;
                end else if (w_touch) begin
                    r_lru[w_idx] <= ~w_hit_way;
                end
            end
            assign w_lru_bit = r_lru[w_idx];
        end else begin : g_no_lru
            assign w_lru_bit = 1'b0;
        end
    endgenerate

    // Next-state and memory/processor handshake outputs
    always_comb begin
        w_next     = r_state;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = {w_tag, w_idx};
        w_touch    = 1'b0;
        w_wr_word  = 1'b0;
        w_fill     = 1'b0;
        case (r_state)
            S_COMPARE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_touch = 1'b1;
                        if (proc_write) begin
                            w_wr_word = 1'b1;
                            if (WRITE_BACK == 0) begin
                                proc_stall = 1'b1;
                                w_next     = S_WTHROUGH;
                            end
                        end
                    end else begin
                        proc_stall = 1'b1;
                        if ((WRITE_BACK != 0) && r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
                            w_next = S_WRITEBACK;
                        end else begin
                            w_next = S_ALLOCATE;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {r_tag[r_way][w_idx], w_idx};
                if (mem_ready) begin
                    w_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    w_fill = 1'b1;
                    w_next = S_COMPARE;
                end
            end
            S_WTHROUGH: begin
                mem_write  = 1'b1;
                proc_stall = ~mem_ready;
                if (mem_ready) begin
                    w_next = S_COMPARE;
                end
            end
            default: w_next = S_COMPARE;
        endcase
        // Reset abandons any transaction without touching memory or storage
        if (proc_reset) begin
            w_next     = S_COMPARE;
            proc_stall = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            w_touch    = 1'b0;
            w_wr_word  = 1'b0;
            w_fill     = 1'b0;
        end
    end

    // Victim block during write-back, freshly written block during write-through
    assign mem_wdata = r_data[r_way][w_idx];

    assign proc_rdata = (proc_read && w_hit && (r_state == S_COMPARE) && !proc_reset)
                        ? r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32] : 32'h0;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= S_COMPARE;
            r_way   <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
            end
        end else begin
            r_state <= w_next;
            if ((r_state == S_COMPARE) && w_req) begin
                r_way <= w_hit ? w_hit_way : w_victim;
            end
            if (w_fill) begin
                r_valid[r_way][w_idx] <= 1'b1;
                r_dirty[r_way][w_idx] <= 1'b0;
            end else if (w_wr_word && (WRITE_BACK != 0)) begin
                r_dirty[w_hit_way][w_idx] <= 1'b1;
            end
        end
    end

    // Tag and block storage; enables already exclude reset cycles
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_way][w_idx] <= mem_rdata;
            r_tag[r_way][w_idx]  <= w_tag;
        end else if (w_wr_word) begin
            r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32] <= proc_wdata;
        end
    end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench: write-back 2-way cache (dut0) and write-through 2-way cache (dut1)
// against a fixed-latency block memory model.
module tb_cache_assoc;

    localparam int LAT = 3;

    logic         clk;
    logic         rst;
    logic         sel;
    logic         p_rd, p_wr;
    logic [29:0]  p_addr;
    logic [31:0]  p_wd;

    logic         d_rd   [2];
    logic         d_wr   [2];
    logic [31:0]  d_rdat [2];
    logic         d_st   [2];
    logic         m_rd   [2];
    logic         m_wr   [2];
    logic [27:0]  m_addr [2];
    logic [127:0] m_wdat [2];
    logic [127:0] m_rdat [2];
    logic         m_rdy  [2];

    logic         c_stall, c_mrd, c_mwr;
    logic [31:0]  c_rdata;

    int checks = 0;
    int errors = 0;

    assign d_rd[0] = p_rd & ~sel;
    assign d_wr[0] = p_wr & ~sel;
    assign d_rd[1] = p_rd & sel;
    assign d_wr[1] = p_wr & sel;
    assign c_stall = sel ? d_st[1]   : d_st[0];
    assign c_rdata = sel ? d_rdat[1] : d_rdat[0];
    assign c_mrd   = sel ? m_rd[1]   : m_rd[0];
    assign c_mwr   = sel ? m_wr[1]   : m_wr[0];

    cache_assoc #(.SETS(8), .WAYS(2), .WRITE_BACK(1)) dut0 (
        .clk(clk), .proc_reset(rst), .proc_read(d_rd[0]), .proc_write(d_wr[0]),
        .proc_addr(p_addr), .proc_wdata(p_wd), .proc_rdata(d_rdat[0]), .proc_stall(d_st[0]),
        .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdat[0]),
        .mem_rdata(m_rdat[0]), .mem_ready(m_rdy[0])
    );

    cache_assoc #(.SETS(8), .WAYS(2), .WRITE_BACK(0)) dut1 (
        .clk(clk), .proc_reset(rst), .proc_read(d_rd[1]), .proc_write(d_wr[1]),
        .proc_addr(p_addr), .proc_wdata(p_wd), .proc_rdata(d_rdat[1]), .proc_stall(d_st[1]),
        .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdat[1]),
        .mem_rdata(m_rdat[1]), .mem_ready(m_rdy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word k of block b is C0DE0000 + b*16 + k
    function automatic logic [127:0] pat(input logic [27:0] b);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) begin
            v[32*k +: 32] = 32'hC0DE_0000 + (32'(b) << 4) + 32'(k);
        end
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mem
        int           cnt;
        int           rd_cnt;
        int           wr_cnt;
        int           tx_n;
        int           wr_seq;
        int           rd_seq;
        logic [27:0]  last_ra;
        logic [27:0]  last_wa;
        logic [127:0] last_wd;

        assign m_rdy[g]  = (m_rd[g] || m_wr[g]) && (cnt == LAT - 1);
        assign m_rdat[g] = pat(m_addr[g]);

        always @(posedge clk) begin
            if (rst || !(m_rd[g] || m_wr[g])) begin
                cnt <= 0;
            end else if (m_rdy[g]) begin
                cnt  <= 0;
                tx_n <= tx_n + 1;
                if (m_wr[g]) begin
                    wr_cnt  <= wr_cnt + 1;
                    wr_seq  <= tx_n;
                    last_wa <= m_addr[g];
                    last_wd <= m_wdat[g];
                end else begin
                    rd_cnt  <= rd_cnt + 1;
                    rd_seq  <= tx_n;
                    last_ra <= m_addr[g];
                end
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One processor request; caller is #1 after a rising edge. Returns stall count and read data.
    task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rdata);
        logic done;
        int   n;
        done   = 1'b0;
        n      = 0;
        stalls = 0;
        rdata  = '0;
        p_rd   = rd;
        p_wr   = wr;
        p_addr = a;
        p_wd   = wd;
        while (!done && n < 60) begin
            @(negedge clk);
            if (!c_stall) begin
                rdata = c_rdata;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        p_rd = 1'b0;
        p_wr = 1'b0;
        check("request_completes", 128'(done), 128'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int          st;
    logic [31:0] rd;
    int          n0;

    initial begin
        rst = 1'b1; sel = 1'b0; p_rd = 1'b1; p_wr = 1'b0; p_addr = 30'h1; p_wd = '0;
        g_mem[0].rd_cnt = 0; g_mem[0].wr_cnt = 0; g_mem[0].tx_n = 0;
        g_mem[1].rd_cnt = 0; g_mem[1].wr_cnt = 0; g_mem[1].tx_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 128'(c_stall), 128'(0));
        check("reset_mem_read", 128'(c_mrd), 128'(0));
        check("reset_mem_write", 128'(c_mwr), 128'(0));
        check("reset_rdata", 128'(c_rdata), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; p_rd = 1'b0;
        @(posedge clk); #1;

        // Cold read of byte 0x4 -> block 0, word 1
        access(1'b1, 1'b0, 30'h1, 32'h0, st, rd);
        check("cold_stall_cycles", 128'(st), 128'(4));
        check("cold_rdata", 128'(rd), 128'(32'hC0DE_0001));
        check("cold_mem_reads", 128'(g_mem[0].rd_cnt), 128'(1));
        check("cold_mem_addr", 128'(g_mem[0].last_ra), 128'(28'h0));

        // Simultaneous read+write behaves as a write
        access(1'b1, 1'b1, 30'h2, 32'h1111_2222, st, rd);
        check("rw_hit_stall", 128'(st), 128'(0));
        access(1'b1, 1'b0, 30'h2, 32'h0, st, rd);
        check("rw_readback", 128'(rd), 128'(32'h1111_2222));
        check("rw_no_mem_write", 128'(g_mem[0].wr_cnt), 128'(0));

        // Dirty eviction in set 0: A=0x20, B=0x40, C=0x60
        do_reset();
        access(1'b0, 1'b1, 30'h20, 32'hAAAA_0001, st, rd);
        check("wr_a_stall", 128'(st), 128'(4));
        access(1'b0, 1'b1, 30'h40, 32'hBBBB_0002, st, rd);
        check("wr_b_stall", 128'(st), 128'(4));
        access(1'b1, 1'b0, 30'h20, 32'h0, st, rd);
        check("rd_a_hit", 128'(st), 128'(0));
        n0 = g_mem[0].tx_n;
        access(1'b1, 1'b0, 30'h60, 32'h0, st, rd);
        check("rd_c_stall", 128'(st), 128'(7));
        check("rd_c_data", 128'(rd), 128'(32'hC0DE_0180));
        check("evict_wr_first", 128'(g_mem[0].wr_seq), 128'(n0));
        check("evict_rd_second", 128'(g_mem[0].rd_seq), 128'(n0 + 1));
        check("evict_wr_addr", 128'(g_mem[0].last_wa), 128'(28'h10));
        check("evict_wr_data", g_mem[0].last_wd,
              {32'hC0DE_0103, 32'hC0DE_0102, 32'hC0DE_0101, 32'hBBBB_0002});
        check("evict_rd_addr", 128'(g_mem[0].last_ra), 128'(28'h18));
        access(1'b1, 1'b0, 30'h20, 32'h0, st, rd);
        check("a_still_hit", 128'(st), 128'(0));
        check("a_data", 128'(rd), 128'(32'hAAAA_0001));

        // Alternating hits, ending on A, leave C as LRU
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, (i % 2 == 0) ? 30'h60 : 30'h20, 32'h0, st, rd);
            check("alt_hit_stall", 128'(st), 128'(0));
            check("alt_hit_data", 128'(rd), (i % 2 == 0) ? 128'(32'hC0DE_0180) : 128'(32'hAAAA_0001));
        end
        n0 = g_mem[0].wr_cnt;
        access(1'b1, 1'b0, 30'h80, 32'h0, st, rd);
        check("lru_evict_stall", 128'(st), 128'(4));
        check("lru_evict_data", 128'(rd), 128'(32'hC0DE_0200));
        check("lru_clean_no_wr", 128'(g_mem[0].wr_cnt), 128'(n0));
        access(1'b1, 1'b0, 30'h20, 32'h0, st, rd);
        check("lru_a_kept", 128'(st), 128'(0));

        // Reset during ALLOCATE abandons the fill
        n0 = g_mem[0].rd_cnt;
        p_rd = 1'b1; p_addr = 30'hA0;
        @(posedge clk); #1;
        @(negedge clk);
        check("alloc_mem_read", 128'(c_mrd), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; p_rd = 1'b0;
        @(negedge clk);
        check("abort_mem_read", 128'(c_mrd), 128'(0));
        check("abort_stall", 128'(c_stall), 128'(0));
        check("abort_no_fill", 128'(g_mem[0].rd_cnt), 128'(n0));
        @(posedge clk); #1;
        access(1'b1, 1'b0, 30'hA0, 32'h0, st, rd);
        check("abort_misses_again", 128'(st), 128'(4));
        check("abort_refill_data", 128'(rd), 128'(32'hC0DE_0280));

        // Write-through instance
        sel = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 30'h100, 32'h0BAD_F00D, st, rd);
        check("wt_miss_stall", 128'(st), 128'(7));
        check("wt_miss_wr_cnt", 128'(g_mem[1].wr_cnt), 128'(1));
        check("wt_miss_wdata", g_mem[1].last_wd,
              {32'hC0DE_0403, 32'hC0DE_0402, 32'hC0DE_0401, 32'h0BAD_F00D});
        access(1'b0, 1'b1, 30'h102, 32'hDEAD_BEEF, st, rd);
        check("wt_hit_stall", 128'(st), 128'(3));
        check("wt_hit_wr_cnt", 128'(g_mem[1].wr_cnt), 128'(2));
        check("wt_hit_addr", 128'(g_mem[1].last_wa), 128'(28'h40));
        check("wt_hit_wdata", g_mem[1].last_wd,
              {32'hC0DE_0403, 32'hDEAD_BEEF, 32'hC0DE_0401, 32'h0BAD_F00D});
        access(1'b1, 1'b0, 30'h102, 32'h0, st, rd);
        check("wt_readback", 128'(rd), 128'(32'hDEAD_BEEF));
        access(1'b1, 1'b0, 30'h120, 32'h0, st, rd);
        check("wt_fill_way1", 128'(st), 128'(4));
        access(1'b1, 1'b0, 30'h140, 32'h0, st, rd);
        check("wt_evict_stall", 128'(st), 128'(4));
        check("wt_evict_no_wr", 128'(g_mem[1].wr_cnt), 128'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter SETS, default 8: number of sets; power of two, 2..64.
REQ-002 Parameter WAYS, default 2: associativity; legal values 1 or 2.
REQ-003 Parameter WRITE_BACK, default 1: 1 = write-back/write-allocate; 0 = write-through/write-allocate.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port proc_reset, input, 1: synchronous, active-high reset.
REQ-006 Port proc_read, input, 1: processor read request.
REQ-007 Port proc_write, input, 1: processor write request.
REQ-008 Port proc_addr, input, 30: word address; [1:0] word-in-block, [IDX+1:2] index, [29:IDX+2] tag, where IDX = log2(SETS).
REQ-009 Port proc_wdata, input, 32: write data.
REQ-010 Port proc_rdata, output, 32: read data; valid when proc_read=1 and proc_stall=0.
REQ-011 Port proc_stall, output, 1: request not yet complete; processor holds its request stable while it is high.
REQ-012 Port mem_read, output, 1: block read request to memory.
REQ-013 Port mem_write, output, 1: block write request to memory.
REQ-014 Port mem_addr, output, 28: block address, equal to byte address [31:4].
REQ-015 Port mem_wdata, output, 128: block write data; word 0 in bits [31:0].
REQ-016 Port mem_rdata, input, 128: block read data; sampled when mem_ready=1.
REQ-017 Port mem_ready, input, 1: single-cycle completion pulse for the outstanding memory request.

Function
REQ-018 Storage per way per set: valid bit, dirty bit (WRITE_BACK=1 only), tag, and a 128-bit block; each set also has one LRU bit when WAYS=2.
REQ-019 FSM states: COMPARE, WRITEBACK, ALLOCATE, WTHROUGH.
REQ-020 COMPARE with no request (proc_read=proc_write=0): proc_stall=0, mem_read=mem_write=0, state unchanged.
REQ-021 If proc_read and proc_write are both 1, the request is treated as a write.
REQ-022 Hit: a valid way matches the tag; proc_stall=0 combinationally in the same cycle, giving zero added latency.
REQ-023 Read hit: proc_rdata is the addressed word of the hit way; the LRU bit is updated so the other way becomes LRU.
REQ-024 Write hit, WRITE_BACK=1: the word is written at the clock edge and dirty is set; the LRU bit is updated.
REQ-025 Write hit, WRITE_BACK=0: the word is written, proc_stall=1, and the FSM enters WTHROUGH.
REQ-026 Miss: proc_stall=1 and a victim way is selected.
REQ-027 Victim selection: an invalid way is chosen first, with way 0 preferred; otherwise the LRU way.
REQ-028 On a miss, the FSM enters WRITEBACK if the victim is valid and dirty; otherwise it enters ALLOCATE.
REQ-029 WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block.
REQ-030 WRITEBACK: on mem_ready=1 the FSM goes to ALLOCATE.
REQ-031 ALLOCATE: mem_read=1, mem_addr={request tag, index}.
REQ-032 ALLOCATE: on mem_ready=1 the block is written to the victim way, valid=1, dirty=0, and the FSM returns to COMPARE.
REQ-033 After ALLOCATE, the retried request hits in COMPARE on the following cycle.
REQ-034 WTHROUGH: mem_write=1, mem_addr={tag, index}, mem_wdata=the updated block.
REQ-035 WTHROUGH: on mem_ready=1, proc_stall=0 in that same cycle and the FSM returns to COMPARE.
REQ-036 Miss latency for a clean victim is mem latency + 1 cycle; a dirty victim adds one full memory write transaction.
REQ-037 Exactly one of mem_read/mem_write is high in WRITEBACK, ALLOCATE and WTHROUGH; both are 0 in COMPARE.
REQ-038 mem_addr and mem_wdata are held stable while the request is pending; a mem_ready received in COMPARE is ignored.
REQ-039 WAYS=1: LRU logic is absent and the victim is always way 0.

Reset
REQ-040 proc_reset=1 at a clock edge clears all valid, dirty and LRU bits and forces state COMPARE.
REQ-041 During reset, mem_read=mem_write=0 and proc_stall=0; proc_rdata=0.
REQ-042 Reset asserted mid-transaction abandons it at the next edge: no fill and no dirty-bit update; memory is not notified.

Verification
REQ-043 Cold read: after reset, read 0x000_0004 with memory latency 3 -> proc_stall high for 4 cycles, one mem_read of block 0x0000000, then data returned with stall=0.
REQ-044 Dirty eviction (SETS=8, WAYS=2): write tags A and B to set 0, read A, then read tag C -> mem_write with B's address and data first, then mem_read of C; A remains a hit afterward.
REQ-045 Write-through (WRITE_BACK=0): write 0xDEADBEEF on a hit -> exactly one mem_write whose mem_wdata contains 0xDEADBEEF in the addressed word; no dirty state is kept.
REQ-046 Simultaneous read+write to one address -> treated as a write; the next read returns proc_wdata.
REQ-047 Reset during ALLOCATE -> mem_read drops at the next cycle and the same address misses again afterward.
REQ-048 Back-to-back hits to alternating ways -> proc_stall=0 every cycle and the LRU bit toggles each access.
